// File: rtl/cache_miss_ctrl_if.sv
// Bundle of CPU-side, cache-side and main-memory signals for the cache miss/refill sequencer.
// slave = the sequencer, master = its surroundings (memory stage, cache arrays, memory port).
interface cache_miss_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4
);
  localparam int IDXW = $clog2(LINE_WORDS);

  logic                  read_en;
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  hit;
  logic                  victim_dirty;
  logic [ADDR_WIDTH-1:0] victim_base;
  logic [DATA_WIDTH-1:0] victim_word;
  logic                  stall;
  logic [IDXW-1:0]       victim_idx;
  logic                  fill_en;
  logic [IDXW-1:0]       fill_idx;
  logic [DATA_WIDTH-1:0] fill_data;
  logic                  fill_done;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [31:0]           miss_count;
  logic [31:0]           wb_count;

  modport slave (
    input  read_en, write_en, addr, hit, victim_dirty, victim_base, victim_word,
           mem_ack, mem_rdata,
    output stall, victim_idx, fill_en, fill_idx, fill_data, fill_done,
           mem_req, mem_we, mem_addr, mem_wdata, miss_count, wb_count
  );

  modport master (
    output read_en, write_en, addr, hit, victim_dirty, victim_base, victim_word,
           mem_ack, mem_rdata,
    input  stall, victim_idx, fill_en, fill_idx, fill_data, fill_done,
           mem_req, mem_we, mem_addr, mem_wdata, miss_count, wb_count
  );
endinterface

// File: rtl/cache_miss_ctrl.sv
// Miss/refill sequencer: stalls on a miss, writes back a dirty victim, refills the line word-by-word.
// Optional performance counters are built only when CACHE_PERF_CNT_EN is defined.
module cache_miss_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  cache_miss_ctrl_if.slave bus
);
  localparam int IDXW = $clog2(LINE_WORDS);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(4 * LINE_WORDS - 1);
  localparam logic [IDXW-1:0]       LAST_IDX = IDXW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, EVICT, REFILL, COMMIT} state_t;

  state_t                state_reg;
  logic [IDXW-1:0]       cnt_reg;
  logic [ADDR_WIDTH-1:0] line_base_reg;
  logic [ADDR_WIDTH-1:0] vic_base_reg;

  logic                  miss;
  logic                  last_word;
  logic                  in_evict;
  logic                  in_refill;
  logic [ADDR_WIDTH-1:0] word_off;

  assign miss      = (bus.read_en | bus.write_en) & ~bus.hit;
  assign last_word = (cnt_reg == LAST_IDX);
  assign in_evict  = (state_reg == EVICT);
  assign in_refill = (state_reg == REFILL);
  assign word_off  = ADDR_WIDTH'({cnt_reg, 2'b00});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      line_base_reg <= '0;
      vic_base_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (miss) begin
            line_base_reg <= bus.addr & ~OFF_MASK;
            vic_base_reg  <= bus.victim_base;
            cnt_reg       <= '0;
            state_reg     <= bus.victim_dirty ? EVICT : REFILL;
          end
        end
        EVICT: begin
          if (bus.mem_ack) begin
            if (last_word) begin
              cnt_reg   <= '0;
              state_reg <= REFILL;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        REFILL: begin
          // The counter wraps back to zero on the last word since LINE_WORDS is a power of two.
          if (bus.mem_ack) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (last_word) state_reg <= COMMIT;
          end
        end
        COMMIT: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Only IDLE stalls combinationally; every other state holds the pipeline.
  assign bus.stall      = (state_reg == IDLE) ? miss : 1'b1;
  assign bus.mem_req    = in_evict | in_refill;
  assign bus.mem_we     = in_evict;
  assign bus.mem_addr   = in_evict  ? (vic_base_reg + word_off)
                        : in_refill ? (line_base_reg + word_off)
                        : '0;
  assign bus.mem_wdata  = in_evict ? bus.victim_word : DATA_WIDTH'(0);
  assign bus.victim_idx = in_evict ? cnt_reg : '0;
  assign bus.fill_en    = in_refill & bus.mem_ack;
  assign bus.fill_idx   = in_refill ? cnt_reg : '0;
  assign bus.fill_data  = in_refill ? bus.mem_rdata : DATA_WIDTH'(0);
  assign bus.fill_done  = (state_reg == COMMIT);

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] miss_count_reg;
  logic [31:0] wb_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_count_reg <= '0;
      wb_count_reg   <= '0;
    end else if ((state_reg == IDLE) && miss) begin
      miss_count_reg <= miss_count_reg + 32'd1;
      if (bus.victim_dirty) wb_count_reg <= wb_count_reg + 32'd1;
    end
  end

  assign bus.miss_count = miss_count_reg;
  assign bus.wb_count   = wb_count_reg;
`else
  assign bus.miss_count = '0;
  assign bus.wb_count   = '0;
`endif
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl (LINE_WORDS=4): hit, clean/dirty misses, mid-burst reset,
// ignored inputs outside IDLE, and performance counters (expected 0 without CACHE_PERF_CNT_EN).
module tb_cache_miss_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;
`ifdef CACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cache_miss_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) bus ();

  cache_miss_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one complete miss; wait_cyc idle cycles precede each ack (0 = ack held high).
  // poke drives a fresh read miss plus a stray ack during COMMIT and the cycle after it.
  task automatic do_miss(input logic [31:0] a, input logic [31:0] base, input bit dirty,
                         input logic [31:0] vb, input int wait_cyc, input bit poke);
    int stalls;
    int exp_stalls;
    logic [31:0] rd;
    stalls = 0;
    exp_stalls = 2 + (dirty ? 2 * LW : LW) * (wait_cyc + 1);
    bus.read_en = 1'b1; bus.write_en = 1'b0; bus.addr = a; bus.hit = 1'b0;
    bus.victim_dirty = dirty; bus.victim_base = vb; bus.mem_ack = (wait_cyc == 0);
    #1;
    check("detect_stall", bus.stall, 1);
    check("detect_req", bus.mem_req, 0);
    stalls += int'(bus.stall);
    if (dirty) begin
      for (int i = 0; i < LW; i++) begin
        for (int w = 0; w <= wait_cyc; w++) begin
          next_cycle();
          bus.hit = 1'b1; bus.victim_dirty = 1'b0; bus.victim_base = 32'hFFFF_FFF0;
          bus.victim_word = 32'hD000_0000 + (vb >> 4) + 32'(i);
          bus.mem_ack = (w == wait_cyc);
          #1;
          stalls += int'(bus.stall);
          check("evict_req", bus.mem_req, 1);
          check("evict_we", bus.mem_we, 1);
          check("evict_addr", bus.mem_addr, vb + 32'(4 * i));
          check("evict_idx", bus.victim_idx, i);
          check("evict_wdata", bus.mem_wdata, 32'hD000_0000 + (vb >> 4) + 32'(i));
          check("evict_fill_en", bus.fill_en, 0);
        end
      end
    end
    for (int i = 0; i < LW; i++) begin
      for (int w = 0; w <= wait_cyc; w++) begin
        next_cycle();
        bus.hit = 1'b1;
        rd = 32'hA500_0000 ^ (base + 32'(4 * i));
        bus.mem_rdata = rd;
        bus.mem_ack = (w == wait_cyc);
        #1;
        stalls += int'(bus.stall);
        check("refill_req", bus.mem_req, 1);
        check("refill_we", bus.mem_we, 0);
        check("refill_addr", bus.mem_addr, base + 32'(4 * i));
        check("refill_fill_en", bus.fill_en, (w == wait_cyc));
        check("refill_done", bus.fill_done, 0);
        if (w == wait_cyc) begin
          check("refill_idx", bus.fill_idx, i);
          check("refill_data", bus.fill_data, rd);
        end
      end
    end
    next_cycle();
    bus.mem_ack = poke;
    if (poke) begin bus.read_en = 1'b1; bus.hit = 1'b0; bus.addr = 32'h7770; end
    #1;
    stalls += int'(bus.stall);
    check("commit_done", bus.fill_done, 1);
    check("commit_stall", bus.stall, 1);
    check("commit_req", bus.mem_req, 0);
    next_cycle();
    bus.read_en = ~poke; bus.hit = 1'b1; bus.addr = a; bus.mem_ack = poke;
    #1;
    stalls += int'(bus.stall);
    check("replay_stall", bus.stall, 0);
    check("replay_req", bus.mem_req, 0);
    check("replay_done", bus.fill_done, 0);
    check("stall_cycles", stalls, exp_stalls);
    next_cycle();
    bus.read_en = 1'b0; bus.hit = 1'b0;
    #1;
    check("after_req", bus.mem_req, 0);
    check("after_stall", bus.stall, 0);
    bus.mem_ack = 1'b0;
    $display("miss addr=0x%08h dirty=%0d victim=0x%08h wait=%0d stall_cycles=%0d", a, dirty, vb, wait_cyc, stalls);
  endtask

  initial begin
    rst = 1'b1;
    bus.read_en = 1'b0; bus.write_en = 1'b0; bus.addr = '0; bus.hit = 1'b0;
    bus.victim_dirty = 1'b0; bus.victim_base = '0; bus.victim_word = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (3) next_cycle();
    check("rst_stall", bus.stall, 0);
    check("rst_req", bus.mem_req, 0);
    check("rst_done", bus.fill_done, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_miss_cnt", bus.miss_count, 0);
    next_cycle();
    rst = 1'b0;

    // Hit: no stall, no request.
    bus.read_en = 1'b1; bus.hit = 1'b1; bus.addr = 32'h100;
    #1;
    check("hit_stall", bus.stall, 0);
    check("hit_req", bus.mem_req, 0);
    next_cycle();
    bus.read_en = 1'b0;
    #1;
    check("hit_req_next", bus.mem_req, 0);
    $display("hit addr=0x00000100 stall=%0d", bus.stall);
    next_cycle();

    // Clean miss with two wait cycles per word; then zero-wait dirty miss.
    do_miss(32'h1234, 32'h1230, 1'b0, 32'h0, 2, 1'b0);
    next_cycle();
    do_miss(32'h2008, 32'h2000, 1'b1, 32'h8000, 0, 1'b0);
    next_cycle();

    // Reset in REFILL after two acks.
    bus.read_en = 1'b1; bus.addr = 32'h3000; bus.hit = 1'b0; bus.victim_dirty = 1'b0; bus.mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) next_cycle();
    check("pre_rst_addr", bus.mem_addr, 32'h3008);
    rst = 1'b1; bus.mem_ack = 1'b0; bus.read_en = 1'b0;
    next_cycle();
    rst = 1'b0;
    #1;
    check("mid_rst_req", bus.mem_req, 0);
    check("mid_rst_stall", bus.stall, 0);
    check("mid_rst_fill_en", bus.fill_en, 0);
    check("mid_rst_done", bus.fill_done, 0);
    check("mid_rst_addr", bus.mem_addr, 0);
    check("mid_rst_fill_data", bus.fill_data, 0);
    check("mid_rst_miss_cnt", bus.miss_count, 0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check("mid_rst_no_done", bus.fill_done, 0);
    end
    $display("reset mid-refill addr=0x00003000 req=%0d stall=%0d", bus.mem_req, bus.stall);

    // New miss restarts at word 0; stray ack and read_en during COMMIT are ignored.
    do_miss(32'h4004, 32'h4000, 1'b0, 32'h0, 0, 1'b1);
    bus.mem_ack = 1'b1;
    next_cycle();
    check("stray_ack_req", bus.mem_req, 0);
    check("stray_ack_miss_cnt", bus.miss_count, PERF ? 1 : 0);
    bus.mem_ack = 1'b0;
    next_cycle();

    // Two more misses (one dirty) for the counters.
    do_miss(32'h5010, 32'h5010, 1'b1, 32'h9000, 1, 1'b0);
    next_cycle();
    do_miss(32'h603C, 32'h6030, 1'b0, 32'h0, 0, 1'b0);
    check("miss_count", bus.miss_count, PERF ? 3 : 0);
    check("wb_count", bus.wb_count, PERF ? 1 : 0);
    $display("counters miss=%0d wb=%0d", bus.miss_count, bus.wb_count);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
